// File: rtl/ps2_key_matrix_pkg.sv
// Shared definitions for the PS/2 keypad decoder: scan-code constants, FSM
// states, event format and the scan-code to CHIP-8 key lookup tables.
package chip8_keys_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_e;

    typedef struct packed {
        logic [3:0] key;
        logic       down;
    } key_event_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] key;
    } key_lookup_t;

    // Left-hand 4x4 block of a QWERTY keyboard laid over the CHIP-8 keypad.
    function automatic key_lookup_t main_map(input logic [7:0] code);
        key_lookup_t r;
        r.hit = 1'b1;
        case (code)
            8'h16:   r.key = 4'h1;
            8'h1E:   r.key = 4'h2;
            8'h26:   r.key = 4'h3;
            8'h25:   r.key = 4'hC;
            8'h15:   r.key = 4'h4;
            8'h1D:   r.key = 4'h5;
            8'h24:   r.key = 4'h6;
            8'h2D:   r.key = 4'hD;
            8'h1C:   r.key = 4'h7;
            8'h1B:   r.key = 4'h8;
            8'h23:   r.key = 4'h9;
            8'h2B:   r.key = 4'hE;
            8'h1A:   r.key = 4'hA;
            8'h22:   r.key = 4'h0;
            8'h21:   r.key = 4'hB;
            8'h2A:   r.key = 4'hF;
            default: begin
                r.hit = 1'b0;
                r.key = 4'h0;
            end
        endcase
        return r;
    endfunction

    function automatic key_lookup_t ext_map(input logic [7:0] code);
        key_lookup_t r;
        r.hit = 1'b1;
        case (code)
            8'h75:   r.key = 4'h2;
            8'h6B:   r.key = 4'h4;
            8'h74:   r.key = 4'h6;
            8'h72:   r.key = 4'h8;
            default: begin
                r.hit = 1'b0;
                r.key = 4'h0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_matrix_if.sv
// Byte input and key-event handshake between the PS/2 receiver, the decoder
// and the CPU-side event consumer.
interface ps2_key_matrix_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ev_valid;
    logic [3:0] ev_key;
    logic       ev_down;
    logic       ev_ready;

    modport master (
        output rx_data, rx_valid, ev_ready,
        input  ev_valid, ev_key, ev_down
    );

    modport slave (
        input  rx_data, rx_valid, ev_ready,
        output ev_valid, ev_key, ev_down
    );
endinterface

// File: rtl/ps2_key_matrix_key_event_fifo.sv
// Small key-event FIFO with a registered first-word-fall-through head.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module key_event_fifo
    import chip8_keys_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       flush_i,
    input  logic       push_i,
    input  key_event_t push_data_i,
    input  logic       pop_i,
    output logic       head_valid_o,
    output key_event_t head_data_o,
    output logic       full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    key_event_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             head_valid_q, head_valid_d;
    key_event_t       head_q, head_d;
    logic             push_ok;
    logic             pop_ok;

    // Pointer, count and head next-state; the head bypasses storage when the
    // pushed entry becomes the oldest one.
    always_comb begin
        pop_ok       = pop_i && (count_q != CNT_ZERO);
        push_ok      = push_i && ((count_q != DEPTH_C) || pop_ok);
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        head_valid_d = head_valid_q;
        head_d       = head_q;
        if (flush_i) begin
            wr_ptr_d     = {PTR_W{1'b0}};
            rd_ptr_d     = {PTR_W{1'b0}};
            count_d      = CNT_ZERO;
            head_valid_d = 1'b0;
            head_d       = '{key: 4'h0, down: 1'b0};
        end else begin
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            count_d      = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
            head_valid_d = (count_d != CNT_ZERO);
            if (push_ok && ((count_q - CNT_W'(pop_ok)) == CNT_ZERO)) begin
                head_d = push_data_i;
            end else if (count_d != CNT_ZERO) begin
                head_d = mem_q[rd_ptr_d];
            end else begin
                head_d = head_q;
            end
        end
    end

    // Control and head registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= CNT_ZERO;
            head_valid_q <= 1'b0;
            head_q       <= '{key: 4'h0, down: 1'b0};
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
        end
    end

    // Event storage.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{key: 4'h0, down: 1'b0};
            end
        end else if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_valid_o = head_valid_q;
    assign head_data_o  = head_q;
    assign full_o       = (count_q == DEPTH_C);

endmodule

// File: rtl/ps2_key_matrix.sv
// PS/2 scan-code decoder for the CHIP-8 keypad: prefix FSM with timeout,
// 16-key matrix and a press/release event queue for the CPU.
module ps2_key_matrix
    import chip8_keys_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 40,
    parameter int EXT_ENABLE     = 1
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               clear,
    ps2_key_matrix_if.slave    bus,
    output logic [15:0]        key_matrix,
    output logic               any_key,
    output logic               overflow
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST =
        (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : {TMO_W{1'b0}};
    localparam key_lookup_t LOOKUP_MISS = '{hit: 1'b0, key: 4'h0};

    kbd_state_e       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [15:0]      key_matrix_q, key_matrix_d;
    logic             any_key_q;
    logic             overflow_q, overflow_d;

    logic             resolve;
    logic             down;
    key_lookup_t      lookup;
    logic             ev_push;
    key_event_t       ev_data;
    logic             fifo_full;
    logic             fifo_valid;
    key_event_t       fifo_head;
    logic             drop;

    // Prefix FSM, timeout, key lookup and matrix/event generation.
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        key_matrix_d = key_matrix_q;
        overflow_d   = overflow_q;
        resolve      = 1'b0;
        down         = (state_q == ST_IDLE) || (state_q == ST_EXT);
        lookup       = LOOKUP_MISS;
        ev_push      = 1'b0;
        ev_data      = '{key: 4'h0, down: 1'b0};
        drop         = 1'b0;
        if (clear) begin
            state_d      = ST_IDLE;
            tmo_d        = {TMO_W{1'b0}};
            key_matrix_d = 16'h0000;
            overflow_d   = 1'b0;
        end else if (bus.rx_valid) begin
            tmo_d = {TMO_W{1'b0}};
            if (bus.rx_data == PS2_EXT) begin
                state_d = ST_EXT;
            end else if ((bus.rx_data == PS2_BREAK) && (state_q != ST_EXT_BRK)) begin
                if (state_q == ST_EXT) begin
                    state_d = ST_EXT_BRK;
                end else begin
                    state_d = ST_BRK;
                end
            end else begin
                state_d = ST_IDLE;
                resolve = 1'b1;
            end
        end else if ((state_q != ST_IDLE) && (TIMEOUT_CYCLES != 0)) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                tmo_d   = {TMO_W{1'b0}};
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end else begin
            tmo_d = {TMO_W{1'b0}};
        end

        if (resolve) begin
            case (state_q)
                ST_IDLE, ST_BRK: lookup = main_map(bus.rx_data);
                ST_EXT, ST_EXT_BRK: begin
                    if (EXT_ENABLE != 0) begin
                        lookup = ext_map(bus.rx_data);
                    end else begin
                        lookup = LOOKUP_MISS;
                    end
                end
                default: lookup = LOOKUP_MISS;
            endcase
        end else begin
            lookup = LOOKUP_MISS;
        end

        // Only real transitions are queued, so typematic repeats vanish here.
        if (lookup.hit && (key_matrix_q[lookup.key] != down)) begin
            key_matrix_d[lookup.key] = down;
            ev_push                  = 1'b1;
            ev_data                  = '{key: lookup.key, down: down};
        end else begin
            ev_push = 1'b0;
        end

        if (ev_push && fifo_full && !(fifo_valid && bus.ev_ready)) begin
            drop       = 1'b1;
            overflow_d = 1'b1;
        end else begin
            drop = 1'b0;
        end
    end

    // Decoder state registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q      <= ST_IDLE;
            tmo_q        <= {TMO_W{1'b0}};
            key_matrix_q <= 16'h0000;
            any_key_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            key_matrix_q <= key_matrix_d;
            any_key_q    <= |key_matrix_d;
            overflow_q   <= overflow_d;
        end
    end

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .res_n        (res_n),
        .flush_i      (clear),
        .push_i       (ev_push),
        .push_data_i  (ev_data),
        .pop_i        (bus.ev_ready),
        .head_valid_o (fifo_valid),
        .head_data_o  (fifo_head),
        .full_o       (fifo_full)
    );

    assign bus.ev_valid = fifo_valid;
    assign bus.ev_key   = fifo_head.key;
    assign bus.ev_down  = fifo_head.down;
    assign key_matrix   = key_matrix_q;
    assign any_key      = any_key_q;
    assign overflow     = overflow_q;

endmodule

// File: doc/ps2_key_matrix.md
# ps2_key_matrix

Scan-code-to-keypad decoder with event queue for the Chip-8 system. It takes byte strobes from the PS/2 receiver, already synchronised into the CPU clock domain. It tracks make/break/extended prefixes and maintains the 16-key CHIP-8 key matrix. Every key state change is also pushed into a small FIFO, so the CPU can implement FX0A (wait for key) without polling races. It replaces the ad-hoc decoding at the top level and adds a prefix timeout, optional arrow-key mapping and press/release event buffering.

## Interface
Parameters:
- FIFO_DEPTH, 4: event queue entries; power of two, 2..16.
- TIMEOUT_CYCLES, 40: clk cycles a prefix state may wait for its next byte; 0 disables timeout.
- EXT_ENABLE, 1: 1 = E0-prefixed arrow keys map to keys 2/4/6/8; 0 = all E0-prefixed codes are ignored.

Ports:
- clk  in  1  clock.
- res_n  in  1  reset. One clock; reset is asynchronous and active-low.
- rx_data  in  8  received scan-code byte.
- rx_valid  in  1  one-cycle strobe qualifying rx_data; at most one byte per cycle.
- clear  in  1  synchronous: release all keys, flush FIFO, clear overflow, FSM to IDLE.
- key_matrix  out  16  bit k = CHIP-8 key k held.
- any_key  out  1  OR of key_matrix.
- ev_valid  out  1  FIFO head valid.
- ev_key  out  4  head event key index.
- ev_down  out  1  head event: 1 = press, 0 = release.
- ev_ready  in  1  consumer pop; pop occurs when ev_valid && ev_ready.
- overflow  out  1  sticky: an event was dropped.

## Operation
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
- Transitions on rx_valid:
  - IDLE: E0→EXT, F0→BRK.
  - EXT: F0→EXT_BRK.
  - E0 received in BRK, EXT or EXT_BRK: restart to EXT.
  - F0 received in BRK: stays in BRK.
  - Any other byte in any state resolves to IDLE.
- Resolution: down = (state is IDLE or EXT).
  - IDLE/BRK: look up byte in the main table:
    - 16→1, 1E→2, 26→3, 25→C, 15→4, 1D→5, 24→6, 2D→D
    - 1C→7, 1B→8, 23→9, 2B→E, 1A→A, 22→0, 21→B, 2A→F
  - EXT/EXT_BRK: only when EXT_ENABLE. 75→2, 6B→4, 74→6, 72→8; all other codes unmapped.
  - Unmapped code: no matrix change, no event.
- Matrix write: key_matrix[k] <= down.
- Events: an event {k, down} is pushed only when the matrix bit actually changes. Typematic repeats and duplicate breaks produce nothing.
- Timeout: a counter runs in any non-IDLE state and reloads on every accepted byte. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE with no side effects.
- E1 (Pause) sequence: handled naturally. Its bytes are unmapped and its F0s resolve harmlessly.
- FIFO full on push: event dropped, overflow set, matrix still updated. Pop and push in the same cycle when full: both succeed.
- clear has priority over a simultaneous rx_valid; that byte is discarded.

## Timing
- Reset values:
  - key_matrix = 0, any_key = 0.
  - ev_valid = 0, ev_key = 0, ev_down = 0.
  - overflow = 0, FSM = IDLE, timeout counter = 0, FIFO empty.
- Byte strobed at edge N:
  - key_matrix and any_key updated at N+1.
  - Pushed event visible at N+1 (ev_valid high) if the FIFO was empty.
- Head outputs are registered, first-word-fall-through. After a pop at edge N, the next entry (or ev_valid = 0) appears at N+1.
- ev_key and ev_down are stable while ev_valid && !ev_ready.
- Back-to-back bytes on consecutive cycles are all accepted; no backpressure on rx.
- Reset asserted mid-sequence: everything returns to reset values immediately. A prefix in flight is lost.

## Structure
- Shared package chip8_keys_pkg holds:
  - scan-code constants (PS2_BREAK = F0, PS2_EXT = E0);
  - FSM state enum;
  - event struct {key[3:0], down};
  - lookup functions main_map(code) and ext_map(code), each returning {hit, key}.
- Sub-module key_event_fifo: synchronous FIFO, parameter DEPTH, FWFT registered head, count-based full/empty, simultaneous push/pop. The decoder FSM and matrix stay in the top module.

## Test plan
- Reset, then bytes 16; F0 16 → key_matrix = 0x0002 after the 16, back to 0x0000 after F0 16. FIFO holds {1,1},{1,0}.
- Byte 1D sent 5 times, then F0 1D → exactly two events, {5,1},{5,0}; any_key high throughout the repeats.
- EXT_ENABLE=1: E0 75, E0 F0 75 → key 2 press then release. EXT_ENABLE=0: same bytes → no change, no events. Plain 75 → ignored in both modes.
- F0, then silence for TIMEOUT_CYCLES+1, then 22 → key 0 pressed (not released); FSM back in IDLE before the 22.
- ev_ready held low, FIFO_DEPTH+1 distinct presses → overflow = 1, FIFO holds the first FIFO_DEPTH events, matrix has all keys set. Then clear → matrix 0, ev_valid 0, overflow 0.
- FIFO full with push and pop on the same edge → count unchanged, no overflow. res_n pulsed low between F0 and 16 → key 1 then presses on the later 16.
